grid_io_cfg_param: RTL
======================

Name: grid_io_cfg_param

Overview:
Parametrised successor to the fixed 4-subtile IO grid tile: NUM_SUBTILES bidirectional GPIO subtiles, each with a 2-bit mode decoded from the configuration chain.
Adds a bit-counting config-chain controller and a double-buffered shadow mode register. Pads stay glitch-free while a new bitstream is shifted in.
Sits on the fabric edge, daisy-chained through ccff_head/ccff_tail with the other grid and switch tiles on prog_clk.

Parameters:
NUM_SUBTILES, 4, number of IO subtiles (1..32)
MODE_BITS, 2, config bits per subtile (fixed at 2; exposed for package consistency)

Ports:
prog_clk  input  1  configuration/fabric clock; all state on rising edge
pReset  input  1  reset; synchronous, active-low (0 = reset on next prog_clk edge)
ccff_head  input  1  config chain serial in
ccff_tail  output  1  config chain serial out (registered)
cfg_shift_en  input  1  shift chain one bit this cycle
cfg_load  input  1  request transfer of chain into shadow mode register
cfg_full  output  1  chain holds a complete bitstream
cfg_loaded  output  1  one-cycle pulse after a successful load
cfg_err  output  1  sticky error flag
pin_outpad  input  NUM_SUBTILES  fabric to pad data, bit i = subtile i
pin_inpad  output  NUM_SUBTILES  pad to fabric data, bit i = subtile i
gfpga_pad_GPIO_PAD  inout  NUM_SUBTILES  physical pads

Behaviour:
- Chain length L = NUM_SUBTILES*MODE_BITS (L+1 with parity feature).
- Shift: when cfg_shift_en=1, chain <= {chain[L-2:0], ccff_head}. ccff_tail = chain[L-1], i.e. the registered MSB. First bit shifted ends at MSB.
- Shadow: mode of subtile i = shadow[2i+1:2i]. Pads are driven only from shadow, never from chain.
- Mode decode (combinational from shadow):
  - 00 DISABLED: pad Z, inpad=0.
  - 01 INPUT: pad Z, inpad=pad.
  - 10 OUTPUT: pad=outpad, inpad=0.
  - 11 LOOPBACK: pad=outpad, inpad=outpad.
- Counter cnt, width $clog2(L+1): +1 per shift, saturates at L. cfg_full = (cnt==L).
- FSM, registered:
  - IDLE (cnt=0): shift -> SHIFT.
  - SHIFT: cnt reaches L -> FULL.
  - FULL: further shifts pass data through to ccff_tail and keep cnt=L; state stays FULL.
- cfg_load in FULL:
  - shadow <= chain value before any same-cycle shift; cnt <= 0; cfg_loaded=1 next cycle; cfg_err cleared.
  - Next state IDLE, or SHIFT with cnt=1 if cfg_shift_en was also 1 that cycle.
- cfg_load in IDLE/SHIFT: ignored, shadow unchanged, cfg_err <= 1 (sticky until reset or a successful load).
- Reset (pReset=0 at edge):
  - chain=0, shadow=0 (all subtiles DISABLED, pads Z, pin_inpad=0), cnt=0, IDLE, ccff_tail=0, cfg_loaded=0, cfg_err=0.
  - Reset overrides shift/load in the same cycle. Reset mid-shift discards partial bitstream.
- Latency: ccff_head to ccff_tail = L cycles of cfg_shift_en. Load to pad change = 1 cycle.

Optional Feature:
Macro GRID_IO_CFG_PARITY_EN.
- Defined:
  - Chain is L+1 bits; chain[L] is the parity bit, shifted in first. Shadow takes chain[L-1:0].
  - On load in FULL, XOR of all L+1 bits must be 0 (even parity). If not: shadow unchanged, cnt <= 0, cfg_err <= 1, no cfg_loaded pulse.
- Undefined: chain is L bits, no check, cfg_err only flags premature loads.

Decomposition:
- Package grid_io_pkg:
  - io_mode_e enum (DISABLED=2'b00, INPUT=2'b01, OUTPUT=2'b10, LOOPBACK=2'b11).
  - MODE_BITS=2.
  - cfg_state_e (IDLE, SHIFT, FULL).
- Sub-module grid_io_cfg_chain: shift register, counter, FSM, parity, shadow register.
- Top holds the generate loop of per-subtile pad muxes.

Test Plan:
1. Reset then idle -> all pads Z, pin_inpad=4'b0000, cfg_full=0, ccff_tail=0.
2. Shift 8 bits 1,0,0,1,1,1,0,0 then cfg_load -> shadow=8'b10011100, cfg_loaded pulse. With pin_outpad=4'b1010, pads externally undriven except pad2=1:
   - pad3=1 (outpad[3]), pad2 input so pin_inpad[2]=1, pad1=1 driven, pin_inpad[1]=1, pad0 Z.
3. cfg_load after 5 shifts -> cfg_err=1, shadow unchanged. Complete 3 more shifts and load -> cfg_err=0.
4. Shift 16 bits with ccff_head pattern A5A5 -> after 8 shifts ccff_tail emits the first byte in order; cfg_full stays 1.
5. Simultaneous cfg_load and cfg_shift_en in FULL -> shadow gets pre-shift value, cnt=1, state SHIFT. pReset=0 mid-shift -> cnt=0, pads Z next edge.
6. With GRID_IO_CFG_PARITY_EN: shift parity 1 plus 8'b00000001 -> load accepted. Parity 0 with the same data -> cfg_err=1, shadow unchanged.

Source files
------------

// File: rtl/grid_io_pkg.sv
// Shared types for the parametrised IO grid tile: per-subtile pad modes and
// config-chain controller states.
package grid_io_pkg;

  localparam int MODE_BITS = 2;

  typedef enum logic [1:0] {
    DISABLED = 2'b00,
    INPUT    = 2'b01,
    OUTPUT   = 2'b10,
    LOOPBACK = 2'b11
  } io_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL
  } cfg_state_e;

endpackage

// File: rtl/grid_io_cfg_chain.sv
// Config chain controller: serial shift register, bit counter, load FSM and
// the shadow mode register. Optional even-parity check under GRID_IO_CFG_PARITY_EN.
module grid_io_cfg_chain
  import grid_io_pkg::*;
#(
  parameter int NUM_SUBTILES = 4
) (
  input  logic                              prog_clk,
  input  logic                              pReset,
  input  logic                              ccff_head,
  input  logic                              cfg_shift_en,
  input  logic                              cfg_load,
  output logic                              ccff_tail,
  output logic                              cfg_full,
  output logic                              cfg_loaded,
  output logic                              cfg_err,
  output logic [NUM_SUBTILES*MODE_BITS-1:0] shadow
);

  localparam int L = NUM_SUBTILES * MODE_BITS;
`ifdef GRID_IO_CFG_PARITY_EN
  localparam int CL = L + 1;
`else
  localparam int CL = L;
`endif
  localparam int CW = $clog2(CL + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CL);

  logic [CL-1:0] chain;
  logic [CW-1:0] cnt;
  cfg_state_e    state;
  logic          par_ok;

`ifdef GRID_IO_CFG_PARITY_EN
  // Parity bit is shifted in first and sits at chain[L]; whole chain must XOR to 0.
  assign par_ok = ~^chain;
`else
  assign par_ok = 1'b1;
`endif

  assign ccff_tail = chain[CL-1];
  assign cfg_full  = (cnt == CNT_MAX);

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      chain      <= '0;
      shadow     <= '0;
      cnt        <= '0;
      state      <= IDLE;
      cfg_loaded <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_loaded <= 1'b0;
      if (cfg_shift_en) chain <= {chain[CL-2:0], ccff_head};
      if (cfg_load && state == FULL) begin
        // Shadow captures the pre-shift chain; a same-cycle shift starts the next bitstream.
        if (par_ok) begin
          shadow     <= chain[L-1:0];
          cfg_loaded <= 1'b1;
          cfg_err    <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
        cnt   <= cfg_shift_en ? CW'(1) : '0;
        state <= cfg_shift_en ? SHIFT : IDLE;
      end else begin
        if (cfg_load) cfg_err <= 1'b1;
        if (cfg_shift_en && state != FULL) begin
          cnt   <= cnt + 1'b1;
          state <= (cnt == CNT_MAX - 1'b1) ? FULL : SHIFT;
        end
      end
    end
  end

endmodule

// File: rtl/grid_io_cfg_param.sv
// Parametrised IO grid tile: config chain plus per-subtile GPIO pad muxes
// driven only from the shadow register. Optional parity: GRID_IO_CFG_PARITY_EN.
module grid_io_cfg_param #(
  parameter int NUM_SUBTILES = 4,
  parameter int MODE_BITS    = 2
) (
  input  logic                    prog_clk,
  input  logic                    pReset,
  input  logic                    ccff_head,
  output logic                    ccff_tail,
  input  logic                    cfg_shift_en,
  input  logic                    cfg_load,
  output logic                    cfg_full,
  output logic                    cfg_loaded,
  output logic                    cfg_err,
  input  logic [NUM_SUBTILES-1:0] pin_outpad,
  output logic [NUM_SUBTILES-1:0] pin_inpad,
  inout  wire  [NUM_SUBTILES-1:0] gfpga_pad_GPIO_PAD
);
  import grid_io_pkg::*;

  logic [NUM_SUBTILES*MODE_BITS-1:0] shadow;

  grid_io_cfg_chain #(
    .NUM_SUBTILES(NUM_SUBTILES)
  ) u_chain (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .ccff_head   (ccff_head),
    .cfg_shift_en(cfg_shift_en),
    .cfg_load    (cfg_load),
    .ccff_tail   (ccff_tail),
    .cfg_full    (cfg_full),
    .cfg_loaded  (cfg_loaded),
    .cfg_err     (cfg_err),
    .shadow      (shadow)
  );

  for (genvar i = 0; i < NUM_SUBTILES; i++) begin : g_sub
    io_mode_e mode;
    assign mode = io_mode_e'(shadow[MODE_BITS*i +: MODE_BITS]);
    assign gfpga_pad_GPIO_PAD[i] = (mode == OUTPUT || mode == LOOPBACK) ? pin_outpad[i] : 1'bz;
    assign pin_inpad[i] = (mode == INPUT)    ? gfpga_pad_GPIO_PAD[i] :
                          (mode == LOOPBACK) ? pin_outpad[i] : 1'b0;
  end

endmodule
